spi_regfile_peripheral: RTL and testbench

- Parametrised SPI target: register file with NUM_REGS entries of DATA_W bits, written and read over a 3-wire-plus-CIPO SPI bus. Generalises the onboarding write-only peripheral.
- Adds: selectable SPI mode, read-back on CIPO, per-frame error reporting, and atomic commit on nCS deassertion.
- Sits between the ui_in/uio pins and the PWM/output logic, which consumes regs_flat.

---
 rtl/spi_regfile_peripheral.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_peripheral.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_regfile_peripheral
// Description : SPI target giving read/write access to a register file of
//               NUM_REGS x DATA_W bits. Writes commit atomically when nCS
//               rises. Bad frames are rejected with a frame_err pulse.
//               The SPI mode is set by CPOL/CPHA.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_regfile_peripheral #(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CMD_W   = 1 + ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    // Data is sampled on the rising SCLK edge in modes 0 and 3.
    localparam bit SAMPLE_ON_RISE = (((CPOL + CPHA) % 2) == 0);
    localparam logic SCLK_IDLE    = (CPOL != 0);

    localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_FULL = 2'd3;

    // ------------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic                   sclk_prev_q;
    logic                   ncs_prev_q;
    logic [SYNC_STAGES:0]   flush_q;
    logic                   armed_q;

    // Shift the asynchronous pins through the synchroniser chains; one
    // extra flop behind the last stage provides the edge reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
            ncs_sync_q  <= '1;
            copi_sync_q <= '0;
            sclk_prev_q <= SCLK_IDLE;
            ncs_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic ncs_s;
    logic copi_s;
    logic flushed;
    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s   = ncs_sync_q[SYNC_STAGES-1];
    assign copi_s  = copi_sync_q[SYNC_STAGES-1];
    assign flushed = flush_q[SYNC_STAGES];

    // The reset values in the chains are not real pin levels. A new frame is
    // accepted only after a genuine high level on nCS has been seen. So a
    // frame in progress while reset is released is ignored until its end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q <= '0;
            armed_q <= 1'b0;
        end else begin
            flush_q <= {flush_q[SYNC_STAGES-1:0], 1'b1};
            if (flushed && ncs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    logic sclk_rise;
    logic sclk_fall;
    logic sample_edge;
    logic shift_edge;
    logic ncs_fall;
    logic ncs_rise;
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign sample_edge = (SAMPLE_ON_RISE ? sclk_rise : sclk_fall) & ~ncs_s;
    assign shift_edge  = (SAMPLE_ON_RISE ? sclk_fall : sclk_rise) & ~ncs_s;
    assign ncs_fall    = armed_q & ncs_prev_q & ~ncs_s;
    assign ncs_rise    = ncs_s & ~ncs_prev_q;

    // ------------------------------------------------------------------------
    // Frame receiver FSM
    // ------------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               rw_q, rw_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               ovr_q, ovr_d;
    logic               load_tx;
    logic               commit;
    logic               err;
    logic               frame_ok;

    assign frame_ok = (cnt_q == CNT_W'(FRAME_W)) && !ovr_q
                      && ({1'b0, addr_q} < NUM_REGS_EXT);

    // Next-state logic: collect bits, latch the command, and judge the frame
    // when nCS rises.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        ovr_d   = ovr_q;
        load_tx = 1'b0;
        commit  = 1'b0;
        err     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                    shift_d = '0;
                    ovr_d   = 1'b0;
                end
            end
            default: begin
                if (ncs_rise) begin
                    state_d = ST_IDLE;
                    if (frame_ok) begin
                        commit = rw_q;
                    end else begin
                        err = 1'b1;
                    end
                end else if (sample_edge) begin
                    case (state_q)
                        ST_CMD: begin
                            shift_d = {shift_q[FRAME_W-2:0], copi_s};
                            cnt_d   = cnt_q + CNT_W'(1);
                            if (cnt_d == CNT_W'(CMD_W)) begin
                                rw_d    = shift_d[ADDR_W];
                                addr_d  = shift_d[ADDR_W-1:0];
                                state_d = ST_DATA;
                                load_tx = ~shift_d[ADDR_W];
                            end
                        end
                        ST_DATA: begin
                            shift_d = {shift_q[FRAME_W-2:0], copi_s};
                            cnt_d   = cnt_q + CNT_W'(1);
                            if (cnt_d == CNT_W'(FRAME_W)) begin
                                state_d = ST_FULL;
                            end
                        end
                        default: begin
                            ovr_d = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    // FSM and receive-path state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            ovr_q   <= ovr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Register file and commit reporting
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_strobe_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              frame_err_q;

    // Registers change only in the cycle after an accepted write frame ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_strobe_q <= commit;
            frame_err_q <= err;
            if (commit) begin
                wr_addr_q <= addr_q;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr_q == ADDR_W'(i)) begin
                        regs_q[i] <= shift_q[DATA_W-1:0];
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_flat
        assign regs_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
    end

    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

    // ------------------------------------------------------------------------
    // Read-back transmit path
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] rd_val;

    // An out-of-range address matches no entry and reads back as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_d == ADDR_W'(i)) begin
                rd_val = regs_q[i];
            end
        end
    end

    logic [DATA_W-1:0] tx_q;
    logic              cipo_q;
    logic              cipo_oe_q;

    // Take a snapshot at the end of the command field, then shift it out MSB
    // first. Zeros fill in behind the data, so cipo stays low after the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q      <= '0;
            cipo_q    <= 1'b0;
            cipo_oe_q <= 1'b0;
        end else if (ncs_rise && (state_q != ST_IDLE)) begin
            tx_q      <= '0;
            cipo_q    <= 1'b0;
            cipo_oe_q <= 1'b0;
        end else if (load_tx) begin
            tx_q      <= rd_val;
            cipo_q    <= 1'b0;
            cipo_oe_q <= 1'b1;
        end else if (cipo_oe_q && shift_edge) begin
            cipo_q    <= tx_q[DATA_W-1];
            tx_q      <= {tx_q[DATA_W-2:0], 1'b0};
        end
    end

    assign cipo    = cipo_q;
    assign cipo_oe = cipo_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile_peripheral.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_regfile_peripheral
// Description : Directed self-checking bench. u_dut0 runs in mode 0 with
//               default parameters. u_dut1 runs in mode 3 with 16-bit data
//               and 8 registers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_regfile_peripheral;

    localparam int HALF = 8;  // SCLK half period in clk cycles

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sclk0, copi0, ncs0, cipo0, cipo_oe0, wr_strobe0, frame_err0;
    logic [39:0]  regs0;
    logic [6:0]   wr_addr0;
    logic         sclk1, copi1, ncs1, cipo1, cipo_oe1, wr_strobe1, frame_err1;
    logic [127:0] regs1;
    logic [6:0]   wr_addr1;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    spi_regfile_peripheral u_dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk0), .copi(copi0), .ncs(ncs0),
        .cipo(cipo0), .cipo_oe(cipo_oe0), .regs_flat(regs0),
        .wr_strobe(wr_strobe0), .wr_addr(wr_addr0), .frame_err(frame_err0)
    );

    spi_regfile_peripheral #(
        .NUM_REGS(8), .DATA_W(16), .ADDR_W(7), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk1), .copi(copi1), .ncs(ncs1),
        .cipo(cipo1), .cipo_oe(cipo_oe1), .regs_flat(regs1),
        .wr_strobe(wr_strobe1), .wr_addr(wr_addr1), .frame_err(frame_err1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mode 0: nCS falls, copi is set up before each rising (sample) edge.
    // cipo/cipo_oe are captured as the controller would sample them.
    task automatic spi0(input logic [31:0] vec, input int w, input int nbits,
                        output logic [31:0] rx, output logic [31:0] oe);
        rx = '0;
        oe = '0;
        ncs0 = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            copi0 = (k < w) ? vec[w-1-k] : 1'b0;
            repeat (HALF) @(negedge clk);
            rx = {rx[30:0], cipo0};
            oe = {oe[30:0], cipo_oe0};
            sclk0 = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk0 = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    // Mode 3: SCLK idles high, falling edge shifts, rising edge samples.
    task automatic spi3(input logic [31:0] vec, input int w, input int nbits,
                        output logic [31:0] rx, output logic [31:0] oe);
        rx = '0;
        oe = '0;
        ncs1 = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < nbits; k++) begin
            sclk1 = 1'b0;
            copi1 = (k < w) ? vec[w-1-k] : 1'b0;
            repeat (HALF) @(negedge clk);
            rx = {rx[30:0], cipo1};
            oe = {oe[30:0], cipo_oe1};
            sclk1 = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    // Raise nCS and watch the following cycles. Counts wr_strobe/frame_err
    // pulses, records the cycle of the first strobe, and snapshots regs at
    // cycle 2.
    task automatic end_frame(input bit which, output int ns, output int ne,
                             output int lat, output logic [127:0] regs_c2);
        ns = 0;
        ne = 0;
        lat = -1;
        regs_c2 = '0;
        if (which) ncs1 = 1'b1; else ncs0 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) regs_c2 = which ? regs1 : {88'b0, regs0};
            if (which ? wr_strobe1 : wr_strobe0) begin
                ns++;
                if (lat < 0) lat = c;
            end
            if (which ? frame_err1 : frame_err0) ne++;
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]  rx, oe;
        logic [127:0] rc2;
        int           ns, ne, lat;

        rst_n = 1'b0;
        sclk0 = 1'b0; copi0 = 1'b0; ncs0 = 1'b1;
        sclk1 = 1'b1; copi1 = 1'b0; ncs1 = 1'b1;
        repeat (5) @(negedge clk);

        // Reset state
        chk("rst_regs0", regs0, 0);
        chk("rst_cipo0", cipo0, 0);
        chk("rst_oe0", cipo_oe0, 0);
        chk("rst_strobe0", wr_strobe0, 0);
        chk("rst_waddr0", wr_addr0, 0);
        chk("rst_err0", frame_err0, 0);
        chk("rst_regs1", regs1, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Write 0x81A5: reg1 = A5
        spi0(32'h81A5, 16, 16, rx, oe);
        chk("wr1_no_partial", regs0, 0);
        end_frame(0, ns, ne, lat, rc2);
        chk("wr1_pre_commit", rc2, 0);
        chk("wr1_latency", 128'(lat), 3);
        chk("wr1_strobes", 128'(ns), 1);
        chk("wr1_errs", 128'(ne), 0);
        chk("wr1_regs", regs0, 40'h00_0000_A500);
        chk("wr1_waddr", wr_addr0, 1);

        // Read 0x0100: returns A5 during the last 8 bits
        spi0(32'h0100, 16, 16, rx, oe);
        chk("rd1_cipo", rx[15:0], 16'h00A5);
        chk("rd1_oe", oe[15:0], 16'h00FF);
        end_frame(0, ns, ne, lat, rc2);
        chk("rd1_strobes", 128'(ns), 0);
        chk("rd1_errs", 128'(ne), 0);
        chk("rd1_oe_after", cipo_oe0, 0);
        chk("rd1_regs", regs0, 40'h00_0000_A500);

        // Out-of-range write to address 5
        spi0(32'h8533, 16, 16, rx, oe);
        end_frame(0, ns, ne, lat, rc2);
        chk("oow_strobes", 128'(ns), 0);
        chk("oow_errs", 128'(ne), 1);
        chk("oow_regs", regs0, 40'h00_0000_A500);

        // Out-of-range read from address 5
        spi0(32'h0500, 16, 16, rx, oe);
        chk("oor_cipo", rx[15:0], 0);
        end_frame(0, ns, ne, lat, rc2);
        chk("oor_errs", 128'(ne), 1);

        // Short frame: 10 bits
        spi0(32'h82FF, 16, 10, rx, oe);
        end_frame(0, ns, ne, lat, rc2);
        chk("short_strobes", 128'(ns), 0);
        chk("short_errs", 128'(ne), 1);
        chk("short_regs", regs0, 40'h00_0000_A500);

        // Long frame: 17 bits
        spi0(32'h82FF, 16, 17, rx, oe);
        end_frame(0, ns, ne, lat, rc2);
        chk("long_strobes", 128'(ns), 0);
        chk("long_errs", 128'(ne), 1);
        chk("long_regs", regs0, 40'h00_0000_A500);

        // Mode 3, 16-bit data: write reg7 = BEEF, then read it back
        spi3(32'h87BEEF, 24, 24, rx, oe);
        chk("m3_no_partial", regs1, 0);
        end_frame(1, ns, ne, lat, rc2);
        chk("m3_latency", 128'(lat), 3);
        chk("m3_strobes", 128'(ns), 1);
        chk("m3_errs", 128'(ne), 0);
        chk("m3_regs", regs1, {16'hBEEF, 112'h0});
        chk("m3_waddr", wr_addr1, 7);
        spi3(32'h070000, 24, 24, rx, oe);
        chk("m3_rd_cipo", rx[23:0], 24'h00BEEF);
        chk("m3_rd_oe", oe[23:0], 24'h00FFFF);
        end_frame(1, ns, ne, lat, rc2);
        chk("m3_rd_errs", 128'(ne), 0);

        // Reset in the middle of a write to reg3
        spi0(32'h8342, 16, 9, rx, oe);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        end_frame(0, ns, ne, lat, rc2);
        chk("rstmid_strobes", 128'(ns), 0);
        chk("rstmid_errs", 128'(ne), 0);
        chk("rstmid_regs", regs0, 0);
        spi0(32'h8342, 16, 16, rx, oe);
        end_frame(0, ns, ne, lat, rc2);
        chk("post_rst_strobes", 128'(ns), 1);
        chk("post_rst_errs", 128'(ne), 0);
        chk("post_rst_regs", regs0, 40'h00_4200_0000);
        chk("post_rst_waddr", wr_addr0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
